// File: rtl/proc_pkg.sv
// Shared processor datapath definitions: default bus width, destination count
// and the demux control-state encoding.
package proc_pkg;

    localparam int WIDTH         = 8;
    localparam int NDEST_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_BCAST
    } state_t;

endpackage

// File: rtl/dest_reg.sv
// Destination holding register: WIDTH bits, synchronous active-high reset,
// loads d only in the cycle its strobe is high.
module dest_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dest_demux.sv
// Registered 1-to-NDEST destination demultiplexer: accepts one bus word over
// valid/ready and writes it into one destination register or into all of them.
module dest_demux
    import proc_pkg::*;
#(
    parameter int WIDTH = proc_pkg::WIDTH,
    parameter int NDEST = NDEST_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(NDEST)-1:0] in_sel,
    input  logic                     in_bcast,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NDEST-1:0]         out_load,
    output logic [NDEST*WIDTH-1:0]   dest_q,
    output logic                     done
);

    localparam int              SELW = $clog2(NDEST);
    localparam logic [SELW-1:0] LAST = SELW'(NDEST - 1);

    state_t            state_q;
    state_t            state_d;
    logic [SELW-1:0]   cnt;
    logic [SELW-1:0]   sel_q;
    logic [WIDTH-1:0]  hold_q;
    logic              done_q;
    logic              accept;

    // Strobes come only from registered state so downstream loads never see input glitches.
    always_comb begin
        state_d  = state_q;
        out_load = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && !reset) begin
                    state_d = in_bcast ? ST_BCAST : ST_WRITE;
                end
            end
            ST_WRITE: begin
                out_load = NDEST'(1) << sel_q;
                state_d  = ST_IDLE;
            end
            ST_BCAST: begin
                out_load = NDEST'(1) << cnt;
                if (cnt == LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready = (state_q == ST_IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign done     = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt     <= '0;
            hold_q  <= '0;
            sel_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ST_WRITE) || ((state_q == ST_BCAST) && (cnt == LAST));
            if (accept) begin
                hold_q <= in_data;
                sel_q  <= in_sel;
                cnt    <= '0;
            end
            // NDEST is a power of two, so the last broadcast step wraps cnt back to 0.
            if (state_q == ST_BCAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NDEST; i++) begin : g_dest
        dest_reg #(
            .WIDTH(WIDTH)
        ) u_dest_reg (
            .clk   (clk),
            .reset (reset),
            .load  (out_load[i]),
            .d     (hold_q),
            .q     (dest_q[i*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_dest_demux.sv
// Self-checking bench for dest_demux: directed cycle table plus randomized
// traffic checked against a transfer-scheduling reference model.
module tb_dest_demux;

    localparam int WIDTH = 8;
    localparam int NDEST = 4;

    logic                   clk;
    logic                   reset;
    logic [WIDTH-1:0]       in_data;
    logic [1:0]             in_sel;
    logic                   in_bcast;
    logic                   in_valid;
    logic                   in_ready;
    logic [NDEST-1:0]       out_load;
    logic [NDEST*WIDTH-1:0] dest_q;
    logic                   done;

    int vectors    = 0;
    int miscompares = 0;

    dest_demux #(
        .WIDTH(WIDTH),
        .NDEST(NDEST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_bcast (in_bcast),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_load (out_load),
        .dest_q   (dest_q),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          vld;
        bit          bc;
        logic [1:0]  sel;
        logic [7:0]  data;
        bit          chkAll;
        bit          eReady;
        logic [3:0]  eLoad;
        bit          eDone;
        logic [31:0] eDest;
    } vec_t;

    // Reference model: a word accepted in cycle k strobes in cycles k+1 .. k+len,
    // then done and ready coincide in cycle k+1+len.
    bit         known = 0;
    bit         active = 0;
    int         startC = 0;
    int         lenC = 0;
    bit         mBc = 0;
    int         mSel = 0;
    logic [7:0] mData = '0;
    int         doneC = -1;
    logic [7:0] mem [NDEST];
    int         cyc = 0;

    function automatic vec_t mk(bit r, bit v, bit b, logic [1:0] s, logic [7:0] d, bit ca,
                                bit er, logic [3:0] el, bit ed, logic [31:0] edst);
        vec_t t;
        t.rst = r; t.vld = v; t.bc = b; t.sel = s; t.data = d; t.chkAll = ca;
        t.eReady = er; t.eLoad = el; t.eDone = ed; t.eDest = edst;
        return t;
    endfunction

    task automatic applyStimulus(input bit r, input bit v, input bit b,
                                 input logic [1:0] s, input logic [7:0] d);
        reset    = r;
        in_valid = v;
        in_bcast = b;
        in_sel   = s;
        in_data  = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, actual, expected);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, then advance the model past the edge.
    task automatic stepCycle(input bit r, input bit v, input bit b, input logic [1:0] s,
                             input logic [7:0] d, input bit useTbl, input vec_t t);
        bit         strobing;
        int         idx;
        logic [3:0] expLoad;
        bit         expReady;
        bit         expDone;
        logic [31:0] expDest;
        applyStimulus(r, v, b, s, d);
        #4;
        strobing = known && active && (cyc >= startC) && (cyc < startC + lenC);
        idx      = mBc ? (cyc - startC) : mSel;
        expLoad  = strobing ? 4'(1 << idx) : 4'b0000;
        expReady = !r && (!active || cyc >= startC + lenC);
        expDone  = (cyc == doneC);
        expDest  = {mem[3], mem[2], mem[1], mem[0]};
        checkOutput("model_ready", {31'b0, in_ready}, {31'b0, expReady});
        if (known) begin
            checkOutput("model_load", {28'b0, out_load}, {28'b0, expLoad});
            checkOutput("model_done", {31'b0, done}, {31'b0, expDone});
            checkOutput("model_dest", dest_q, expDest);
        end
        if (useTbl) begin
            checkOutput("tbl_ready", {31'b0, in_ready}, {31'b0, t.eReady});
            if (t.chkAll) begin
                checkOutput("tbl_load", {28'b0, out_load}, {28'b0, t.eLoad});
                checkOutput("tbl_done", {31'b0, done}, {31'b0, t.eDone});
                checkOutput("tbl_dest", dest_q, t.eDest);
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            known  = 1;
            active = 0;
            doneC  = -1;
            for (int i = 0; i < NDEST; i++) mem[i] = '0;
        end else begin
            if (strobing) mem[idx] = mData;
            if (v && expReady) begin
                active = 1;
                startC = cyc + 1;
                lenC   = b ? NDEST : 1;
                mBc    = b;
                mSel   = int'(s);
                mData  = d;
                doneC  = cyc + 1 + lenC;
            end
        end
        cyc++;
    endtask

    vec_t tbl [28];

    initial begin
        vec_t dummy;
        for (int i = 0; i < NDEST; i++) mem[i] = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        dummy = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset, idle, single write, held-valid back-to-back, broadcast with busy-time
        // input changes, and a reset landing on the second broadcast strobe.
        tbl[0]  = mk(1, 0, 0, 2'd0, 8'h00, 0, 0, 4'b0000, 0, 32'h00000000);
        tbl[1]  = mk(1, 0, 0, 2'd0, 8'h00, 0, 0, 4'b0000, 0, 32'h00000000);
        tbl[2]  = mk(0, 0, 0, 2'd0, 8'h00, 1, 1, 4'b0000, 0, 32'h00000000);
        tbl[3]  = mk(0, 0, 0, 2'd1, 8'h33, 1, 1, 4'b0000, 0, 32'h00000000);
        tbl[4]  = mk(0, 0, 1, 2'd2, 8'h44, 1, 1, 4'b0000, 0, 32'h00000000);
        tbl[5]  = mk(0, 0, 0, 2'd3, 8'h55, 1, 1, 4'b0000, 0, 32'h00000000);
        tbl[6]  = mk(0, 0, 0, 2'd0, 8'h66, 1, 1, 4'b0000, 0, 32'h00000000);
        tbl[7]  = mk(0, 1, 0, 2'd2, 8'h1C, 1, 1, 4'b0000, 0, 32'h00000000);
        tbl[8]  = mk(0, 0, 0, 2'd0, 8'h00, 1, 0, 4'b0100, 0, 32'h00000000);
        tbl[9]  = mk(0, 0, 0, 2'd0, 8'h00, 1, 1, 4'b0000, 1, 32'h001C0000);
        tbl[10] = mk(0, 0, 0, 2'd0, 8'h00, 1, 1, 4'b0000, 0, 32'h001C0000);
        tbl[11] = mk(0, 1, 0, 2'd0, 8'h02, 1, 1, 4'b0000, 0, 32'h001C0000);
        tbl[12] = mk(0, 1, 0, 2'd3, 8'h1E, 1, 0, 4'b0001, 0, 32'h001C0000);
        tbl[13] = mk(0, 1, 0, 2'd3, 8'h1E, 1, 1, 4'b0000, 1, 32'h001C0002);
        tbl[14] = mk(0, 0, 0, 2'd0, 8'h00, 1, 0, 4'b1000, 0, 32'h001C0002);
        tbl[15] = mk(0, 0, 0, 2'd0, 8'h00, 1, 1, 4'b0000, 1, 32'h1E1C0002);
        tbl[16] = mk(0, 1, 1, 2'd2, 8'h07, 1, 1, 4'b0000, 0, 32'h1E1C0002);
        tbl[17] = mk(0, 0, 0, 2'd1, 8'hFF, 1, 0, 4'b0001, 0, 32'h1E1C0002);
        tbl[18] = mk(0, 0, 0, 2'd1, 8'hFF, 1, 0, 4'b0010, 0, 32'h1E1C0007);
        tbl[19] = mk(0, 0, 0, 2'd1, 8'hFF, 1, 0, 4'b0100, 0, 32'h1E1C0707);
        tbl[20] = mk(0, 0, 0, 2'd1, 8'hFF, 1, 0, 4'b1000, 0, 32'h1E070707);
        tbl[21] = mk(0, 0, 0, 2'd0, 8'h00, 1, 1, 4'b0000, 1, 32'h07070707);
        tbl[22] = mk(0, 0, 0, 2'd0, 8'h00, 1, 1, 4'b0000, 0, 32'h07070707);
        tbl[23] = mk(0, 1, 1, 2'd0, 8'h5A, 1, 1, 4'b0000, 0, 32'h07070707);
        tbl[24] = mk(0, 0, 0, 2'd0, 8'h00, 1, 0, 4'b0001, 0, 32'h07070707);
        tbl[25] = mk(1, 0, 0, 2'd0, 8'h00, 1, 0, 4'b0010, 0, 32'h0707075A);
        tbl[26] = mk(0, 0, 0, 2'd0, 8'h00, 1, 1, 4'b0000, 0, 32'h00000000);
        tbl[27] = mk(0, 0, 0, 2'd0, 8'h00, 1, 1, 4'b0000, 0, 32'h00000000);

        @(posedge clk);
        #1;
        $display("[TB] directed table");
        for (int i = 0; i < 28; i++) begin
            stepCycle(tbl[i].rst, tbl[i].vld, tbl[i].bc, tbl[i].sel, tbl[i].data, 1'b1, tbl[i]);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            stepCycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
                      ($urandom_range(0, 3) == 0), 2'($urandom), 8'($urandom), 1'b0, dummy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dest_demux.md
# dest_demux

Registered 1-to-NDEST destination demultiplexer: the distribution side of the processor's 2:1 source-select mux. The select mux picks one of two 8-bit sources onto the internal bus. This block takes a bus value plus a destination index and writes it into exactly one of NDEST destination holding registers, or into all of them in sequence. Each write is announced with a per-destination load strobe. Upstream hands words in over a valid/ready handshake; the datapath registers consume `dest_q`/`out_load`.

## Interface
- `WIDTH`, 8, data width in bits.
- `NDEST`, 4, number of destinations; power of two, ≥ 2.
- `SELW`, $clog2(NDEST), width of the destination index (derived, not overridden).

- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  bus value to distribute.
- `in_sel`  in  SELW  destination index (ignored when `in_bcast`=1).
- `in_bcast`  in  1  1 = write `in_data` to every destination.
- `in_valid`  in  1  upstream offers a word.
- `in_ready`  out  1  block can accept a word this cycle.
- `out_load`  out  NDEST  one-hot load strobe; bit i high in the cycle destination i is written.
- `dest_q`  out  NDEST*WIDTH  destination registers; slice i = `dest_q[i*WIDTH +: WIDTH]`.
- `done`  out  1  one-cycle pulse after the final write of a transfer.

## Operation
- States: IDLE, WRITE, BCAST.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, capture `in_data` → `hold_q` and `in_sel` → `sel_q`.
  - Go to BCAST (counter `cnt`=0) if `in_bcast`=1, else go to WRITE.
  - Without `in_valid`, stay in IDLE.
- WRITE:
  - `out_load`=1<<`sel_q`, `in_ready`=0.
  - At the end of the cycle: `dest_q[sel_q]` ← `hold_q`, `done` registered high, next state IDLE.
- BCAST:
  - `out_load`=1<<`cnt`, `in_ready`=0.
  - Each edge: `dest_q[cnt]` ← `hold_q`, `cnt`++.
  - When `cnt`=NDEST-1, the edge also sets `done` and returns to IDLE; `cnt` wraps to 0.
- `out_load` is exactly one-hot in WRITE/BCAST and all-zero in IDLE. It is decoded from state and is combinational from registers only, with no path from inputs.
- Non-addressed destinations hold their value. A destination is never written outside its strobe cycle.
- `in_sel`/`in_bcast`/`in_data` are don't-care unless `in_valid`&&`in_ready`. Changes to them while busy have no effect.
- `in_valid` may stay high across a busy period. The word is accepted on the first IDLE cycle, and the word offered at that moment is the one taken.
- `done` is high for exactly one cycle: the first cycle back in IDLE. A new word may be accepted in that same cycle.
- Reset (any state, including mid-BCAST):
  - next state IDLE, `cnt`=0, `hold_q`=0, `sel_q`=0;
  - every `dest_q` slice=0, `done`=0;
  - the in-flight transfer is abandoned, with no further strobes.
  - `in_ready` is forced 0 while `reset` is high.

## Timing
- Reset values (cycle after reset edge): `in_ready`=1, `out_load`=0, `dest_q`=0, `done`=0.
- Single write, accepted at edge E0:
  - `out_load` valid in cycle E0..E1;
  - `dest_q[sel]` shows new value after E1;
  - `done` high E1..E2, `in_ready` high again from E1.
  - Throughput: one word per 2 cycles.
- Broadcast, accepted at E0:
  - strobes on destinations 0,1,…,NDEST-1 in consecutive cycles;
  - `dest_q[i]` updated at edge E(i+1);
  - `done` in cycle after E(NDEST), `in_ready` high from E(NDEST).
  - Total NDEST+1 cycles per word.
- Latency from accept to visible write: 2 edges for a single write; i+2 edges for broadcast destination i.

## Structure
- Shared package `proc_pkg`: `WIDTH` default constant (8), the state enum (`ST_IDLE`, `ST_WRITE`, `ST_BCAST`), and a `NDEST_DEFAULT`=4 constant.
- One sub-module is natural: `dest_reg`, a WIDTH-bit synchronous-reset register with load enable. It is instantiated NDEST times in a generate loop, with `out_load[i]` as the enable and `hold_q` as D.
- FSM, counter and handshake live in `dest_demux` itself.

## Test plan
- Reset then idle: hold `reset`=1 for 2 cycles, release.
  - Expect `in_ready`=1, `out_load`=0, all `dest_q`=0, `done`=0.
  - With `in_valid`=0 for 5 cycles, nothing changes.
- Single write: `in_data`=8'h1C, `in_sel`=2, `in_valid`=1 for one cycle.
  - Next cycle `out_load`=4'b0100 and `in_ready`=0.
  - Then `dest_q[2]`=8'h1C, others 0, `done` pulses once.
- Back-to-back held valid: `in_valid` held high.
  - Word A (8'h02, sel 0) then word B (8'h1E, sel 3).
  - B is accepted on the `done` cycle of A.
  - Result: `dest_q[0]`=8'h02, `dest_q[3]`=8'h1E, strobes 0001 then 1000, 2 cycles apart.
- Broadcast: `in_data`=8'h07, `in_bcast`=1.
  - `out_load` walks 0001, 0010, 0100, 1000 on consecutive cycles.
  - All slices become 8'h07, `done` one cycle after the last strobe, `in_ready`=0 throughout.
- Input changes while busy: during the broadcast, drive `in_data`=8'hFF and `in_sel`=1 with `in_valid`=0.
  - All destinations still receive 8'h07.
- Reset mid-broadcast: assert `reset` in the cycle `out_load`=0010.
  - Next cycle `out_load`=0, all `dest_q`=0, `done`=0, state IDLE.
  - After release, `in_ready`=1.
